// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin mux arbiter.
//   arb_state_e : arbiter FSM states
//   ARB_N       : number of requesters sharing the mux
//   ARB_IDX_W   : width of a requester index / mux select
package arb_pkg;

  localparam int ARB_N     = 4;
  localparam int ARB_IDX_W = 2;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_OWN  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick.
//   req    : request vector
//   last   : round-robin pointer (most recent owner)
//   winner : first requester found scanning last+1, last+2, last+3, last
//   found  : high when any request bit is set
module rr_pick
  import arb_pkg::*;
(
  input  logic [ARB_N-1:0]     req,
  input  logic [ARB_IDX_W-1:0] last,
  output logic [ARB_IDX_W-1:0] winner,
  output logic                 found
);

  logic [ARB_IDX_W-1:0] idx;

  // Scan from the farthest offset down to the nearest so the last hit,
  // which overrides earlier ones, is the closest requester after `last`.
  // Offset ARB_N truncates to 0, i.e. `last` itself has lowest priority.
  always_comb begin
    winner = last;
    found  = 1'b0;
    idx    = last;
    for (int k = ARB_N; k >= 1; k--) begin
      idx = last + k[ARB_IDX_W-1:0];
      if (req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter owning the select of a shared 4-to-1 mux.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   req   : per-requester request, bit i -> mux input d{i}
//   grant : registered one-hot owner, zero when idle
//   sel   : registered mux select (owner index, held while idle)
//   busy  : registered, high while a grant is active
//
// state    | meaning
// ARB_IDLE | no owner; grant/busy low, sel holds previous owner
// ARB_OWN  | sel_q owns the mux; hold_q counts tenure cycles
module rr_mux_arbiter
  import arb_pkg::*;
#(
  parameter int HOLD_MAX = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ARB_N-1:0]     req,
  output logic [ARB_N-1:0]     grant,
  output logic [ARB_IDX_W-1:0] sel,
  output logic                 busy
);

  localparam int                CNT_W     = $clog2(HOLD_MAX + 1);
  localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLD_MAX - 1);
  localparam logic [ARB_N-1:0]  ONE_HOT0  = {{(ARB_N-1){1'b0}}, 1'b1};

  arb_state_e           state_q, state_d;
  logic [ARB_IDX_W-1:0] last_q, last_d;
  logic [ARB_IDX_W-1:0] sel_q, sel_d;
  logic [CNT_W-1:0]     hold_q, hold_d;
  logic [ARB_N-1:0]     grant_q, grant_d;
  logic                 busy_q, busy_d;

  logic [ARB_IDX_W-1:0] pick_winner;
  logic                 pick_found;
  logic                 others;
  logic                 take;

  // While owning, last_q equals the owner, so one pick serves both paths;
  // on timeout the owner sits at the lowest priority of the scan.
  rr_pick u_pick (
    .req    (req),
    .last   (last_q),
    .winner (pick_winner),
    .found  (pick_found)
  );

  assign others = |(req & ~(ONE_HOT0 << sel_q));

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    sel_d   = sel_q;
    hold_d  = hold_q;
    grant_d = grant_q;
    busy_d  = busy_q;
    take    = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        take = pick_found;
      end
      ARB_OWN: begin
        if (!req[sel_q]) begin
          if (others) begin
            take = 1'b1;
          end else begin
            state_d = ARB_IDLE;
            grant_d = '0;
            busy_d  = 1'b0;
            hold_d  = '0;
          end
        end else if (hold_q == HOLD_LAST) begin
          if (others) take = 1'b1;
          else        hold_d = '0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase

    if (take) begin
      state_d = ARB_OWN;
      last_d  = pick_winner;
      sel_d   = pick_winner;
      grant_d = ONE_HOT0 << pick_winner;
      busy_d  = 1'b1;
      hold_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      last_q  <= ARB_IDX_W'(ARB_N - 1);
      sel_q   <= '0;
      hold_q  <= '0;
      grant_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      hold_q  <= hold_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
    end
  end

  assign grant = grant_q;
  assign sel   = sel_q;
  assign busy  = busy_q;

endmodule

// File: doc/rr_mux_arbiter.md
# rr_mux_arbiter

Round-robin arbiter that shares one 4-to-1 multiplexer between four requesters. It decides which requester owns the mux, drives the 2-bit select and a one-hot grant, and bounds each tenure with a hold limit. It sits directly in front of the 4-to-1 datapath mux, so the mux's `sel` input is always driven from a registered, glitch-free source.

## Interface
Parameters:
- `HOLD_MAX`, default 8: maximum consecutive cycles one owner keeps the grant while others wait. Legal range 1..255.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  4  request per requester; bit i maps to mux input `d{i}`.
- `grant`  out  4  one-hot ownership, or all-zero when idle; registered.
- `sel`  out  2  select for the shared 4-to-1 mux; equals the owner's index; registered.
- `busy`  out  1  high while any grant is active; registered.

## Operation
- State machine has two states, IDLE and OWN. `owner[1:0]` holds the current owner. `last[1:0]` holds the most recent owner and is the round-robin pointer. `hold_cnt` is `$clog2(HOLD_MAX+1)` bits wide.
- Pick function: scan indices `last+1, last+2, last+3, last` (mod 4) and take the first one with `req` high. Wrap-around is plain 2-bit modular addition.
- IDLE:
  - If `req` is nonzero, pick a winner. Next state is OWN, with `owner = last = winner`, `hold_cnt = 0`, `grant = 1<<winner`, `sel = winner` and `busy = 1`.
  - Otherwise stay in IDLE.
- OWN, with the owner sampled as `o`:
  - **Release.** `req[o]` is low. If another request is pending, hand off directly to the pick (with `last = o`) and restart `hold_cnt` at 0; there is no bubble. If no other request is pending, go to IDLE with `grant = 0` and `busy = 0`.
  - **Timeout.** `req[o]` is high and `hold_cnt == HOLD_MAX-1`. If another request is pending, force a handoff to the pick. The pick excludes `o` because it lands on `o` last. If no other request is pending, `o` keeps the grant and `hold_cnt` reloads to 0.
  - **Otherwise.** Increment `hold_cnt` by 1.
- `sel` holds its last value while in IDLE, so the mux output is don't-care but stable. `sel` changes only on a grant edge.
- Invariant: `grant` is either zero or one-hot, and `grant[sel]` is 1 whenever `busy` is 1.
- Reset values: `grant = 0`, `sel = 0`, `busy = 0`, state IDLE, `last = 3` so requester 0 has first priority, `hold_cnt = 0`.
- Reset mid-tenure clears everything asynchronously. Requests present at reset release are arbitrated fresh on the first edge, starting from requester 0.

## Timing
- Request-to-grant latency is 1 cycle. A `req` sampled at edge N gives `grant`, `sel` and `busy` valid after edge N.
- Release latency is 1 cycle. A `req[o]` drop sampled at edge N clears or reassigns the grant after edge N.
- A handoff is zero-bubble: the old grant deasserts and the new grant asserts on the same edge.
- Maximum continuous tenure under contention is HOLD_MAX cycles. Worst-case wait for a requester that holds `req` high is `3*HOLD_MAX + 1` cycles.
- Requesters must hold `req` until granted. A request dropped before grant is simply not served. This is legal and raises no error.
- When all four `req` bits rise on the same edge, the winner is `last+1`.

## Structure
- Shared package `arb_pkg`:
  - state enum `{ARB_IDLE, ARB_OWN}`
  - `ARB_N = 4`
  - `ARB_IDX_W = 2`
- Sub-module `rr_pick` is purely combinational. It takes `req[3:0]` and `last[1:0]` and returns `winner[1:0]` and `found`. It is reused for both the IDLE and OWN paths.
- The top level holds the FSM, the `hold_cnt` counter and the output registers.

## Test plan
- **Reset.** Hold `rst_n` low with `req = 4'b1111`. Required: `grant = 0`, `sel = 0`, `busy = 0`. Release reset; one edge later `grant = 4'b0001` and `sel = 0`.
- **Single requester.** Assert `req = 4'b0100` for 20 cycles with `HOLD_MAX = 8`. Required: `grant = 4'b0100` and `sel = 2` continuously with no gap. Drop `req`; one edge later `grant = 0` and `busy = 0`, and `sel` stays 2.
- **Rotation under full contention.** Hold `req = 4'b1111` with `HOLD_MAX = 4`. Required: grant sequence 0, 1, 2, 3, 0, each exactly 4 cycles, zero-bubble handoffs, one-hot at all times.
- **Early release handoff.** Owner 1 holds; `req[3]` is pending; `req[1]` drops at cycle 2 of the tenure. Required: on the next edge `grant = 4'b1000`, `sel = 3`, `hold_cnt` restarted. Then owner 3 drops with `req[0]` high; required: `grant = 4'b0001` on the next edge.
- **Pointer wrap.** Set `last = 3` via owner 3, then assert only `req = 4'b1001`. Required: requester 0 is granted, not 3.
- **Reset mid-tenure.** Pulse `rst_n` low asynchronously (between edges) while owner 2 holds. Required: outputs clear immediately, without waiting for a clock edge. After release, with `req = 4'b0100`, `grant = 4'b0100` one edge later.
